// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receive path with oversampled start detection, 5-8 data bits,
// optional even/odd parity, stop-bit check and break detection. Received characters,
// each tagged with parity/framing error bits, go into a first-word-fall-through FIFO.
// The FIFO raises a trigger-level interrupt and an idle-line timeout interrupt.
//
// Ports:
//   clk, rst            system clock; asynchronous active-low reset
//   cfg_div             clk cycles per baud tick (0 and 1 both mean every cycle)
//   cfg_wlen            data bits 00=5 .. 11=8; cfg_par_en / cfg_par_even select parity
//   rx_i                asynchronous serial input, idle high
//   rd_valid/rd_ready   FIFO pop handshake; rd_data/rd_pe/rd_fe give the head entry
//   fifo_flush          synchronous FIFO clear
//   trig_level          level-irq threshold (0 disables); fifo_count gives occupancy
//   overrun_o/ovr_clr   sticky overrun flag and its clear
//   break_o             one-cycle pulse on break detection
//   irq_o               registered level-or-timeout interrupt
module uart_rx_fifo #(
  parameter int FIFO_DEPTH   = 16,
  parameter int OVERSAMPLE   = 16,
  parameter int DIV_WIDTH    = 16,
  parameter int TIMEOUT_BITS = 40,
  localparam int AW          = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic [1:0]           cfg_wlen,
  input  logic                 cfg_par_en,
  input  logic                 cfg_par_even,
  input  logic                 rx_i,
  output logic                 rd_valid,
  output logic [7:0]           rd_data,
  output logic                 rd_pe,
  output logic                 rd_fe,
  input  logic                 rd_ready,
  input  logic                 fifo_flush,
  input  logic [AW:0]          trig_level,
  output logic [AW:0]          fifo_count,
  output logic                 overrun_o,
  input  logic                 ovr_clr,
  output logic                 break_o,
  output logic                 irq_o
);

  localparam int SW       = $clog2(OVERSAMPLE);
  localparam int TO_LIMIT = TIMEOUT_BITS * OVERSAMPLE;
  localparam int TW       = $clog2(TO_LIMIT + 1);
  localparam logic [SW-1:0] SMP_MID = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SMP_END = SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT
  } state_t;

  function automatic logic calc_pe(input logic [7:0] d, input logic p,
                                   input logic en, input logic even);
    calc_pe = en && ((^{d, p}) != !even);
  endfunction

  // Stage p0: rx synchroniser and baud tick
  logic [1:0]           rx_sync;
  logic                 rx_bit;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [DIV_WIDTH-1:0] div_last;
  logic                 tick;

  assign rx_bit   = rx_sync[1];
  assign div_last = (cfg_div > DIV_WIDTH'(1)) ? cfg_div - DIV_WIDTH'(1) : '0;
  // >= rather than == so a live shrink of cfg_div still wraps at once
  assign tick     = (div_cnt >= div_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync <= 2'b11;
      div_cnt <= '0;
    end else begin
      rx_sync <= {rx_sync[0], rx_i};
      div_cnt <= tick ? '0 : div_cnt + DIV_WIDTH'(1);
    end
  end

  // Stage p0 -> p1: frame FSM, push request registered for the FIFO
  state_t      state, state_n;
  logic [SW-1:0] s_cnt, s_n;
  logic [2:0]  bit_idx, bit_n, last_bit;
  logic [1:0]  wlen_l, wlen_n;
  logic        pen_l, pen_n, pev_l, pev_n;
  logic [7:0]  data_sr, data_n;
  logic        par_bit, par_n;
  logic        push_vld_p1, push_n;
  logic [9:0]  push_word_p1, word_n;
  logic        brk_n;

  assign last_bit = {1'b0, wlen_l} + 3'd4;

  always_comb begin
    state_n = state;
    s_n     = s_cnt;
    bit_n   = bit_idx;
    wlen_n  = wlen_l;
    pen_n   = pen_l;
    pev_n   = pev_l;
    data_n  = data_sr;
    par_n   = par_bit;
    push_n  = 1'b0;
    word_n  = push_word_p1;
    brk_n   = 1'b0;
    if (tick) begin
      case (state)
        S_IDLE: if (!rx_bit) begin
          state_n = S_START;
          s_n     = '0;
          bit_n   = '0;
          data_n  = '0;
          par_n   = 1'b0;
          wlen_n  = cfg_wlen;
          pen_n   = cfg_par_en;
          pev_n   = cfg_par_even;
        end
        S_START: if (s_cnt == SMP_MID) begin
          s_n     = '0;
          state_n = rx_bit ? S_IDLE : S_DATA;
        end else s_n = s_cnt + SW'(1);
        S_DATA: if (s_cnt == SMP_END) begin
          s_n             = '0;
          data_n[bit_idx] = rx_bit;
          if (bit_idx == last_bit) state_n = pen_l ? S_PARITY : S_STOP;
          else                     bit_n   = bit_idx + 3'd1;
        end else s_n = s_cnt + SW'(1);
        S_PARITY: if (s_cnt == SMP_END) begin
          s_n     = '0;
          par_n   = rx_bit;
          state_n = S_STOP;
        end else s_n = s_cnt + SW'(1);
        S_STOP: if (s_cnt == SMP_END) begin
          s_n    = '0;
          push_n = 1'b1;
          word_n = {!rx_bit, calc_pe(data_sr, par_bit, pen_l, pev_l), data_sr};
          if ((data_sr == 8'd0) && !(pen_l && par_bit) && !rx_bit) begin
            brk_n   = 1'b1;
            state_n = S_BRK_WAIT;
          end else state_n = S_IDLE;
        end else s_n = s_cnt + SW'(1);
        S_BRK_WAIT: if (rx_bit) state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      s_cnt       <= '0;
      bit_idx     <= '0;
      wlen_l      <= '0;
      pen_l       <= 1'b0;
      pev_l       <= 1'b0;
      push_vld_p1 <= 1'b0;
      break_o     <= 1'b0;
    end else begin
      state       <= state_n;
      s_cnt       <= s_n;
      bit_idx     <= bit_n;
      wlen_l      <= wlen_n;
      pen_l       <= pen_n;
      pev_l       <= pev_n;
      push_vld_p1 <= push_n;
      break_o     <= brk_n;
    end
  end

  always_ff @(posedge clk) begin
    data_sr      <= data_n;
    par_bit      <= par_n;
    push_word_p1 <= word_n;
  end

  // Stage p1 -> p2: FIFO storage, overrun, timeout and interrupt
  logic [9:0]    mem [FIFO_DEPTH];
  logic [9:0]    head;
  logic [AW-1:0] wptr, rptr;
  logic          full, do_push, do_pop, ovr_set, to_evt;
  logic [TW-1:0] to_cnt;
  logic          timeout_flag;

  assign rd_valid = (fifo_count != '0);
  assign full     = (fifo_count == (AW+1)'(FIFO_DEPTH));
  assign do_pop   = rd_valid && rd_ready && !fifo_flush;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign do_push  = push_vld_p1 && !fifo_flush && (!full || do_pop);
  assign ovr_set  = push_vld_p1 && !fifo_flush && full && !do_pop;
  assign to_evt   = do_push || do_pop || fifo_flush;
  assign head     = mem[rptr];
  assign rd_data  = rd_valid ? head[7:0] : 8'd0;
  assign rd_pe    = rd_valid && head[8];
  assign rd_fe    = rd_valid && head[9];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_word_p1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr         <= '0;
      rptr         <= '0;
      fifo_count   <= '0;
      overrun_o    <= 1'b0;
      to_cnt       <= '0;
      timeout_flag <= 1'b0;
      irq_o        <= 1'b0;
    end else begin
      if (fifo_flush) begin
        wptr       <= '0;
        rptr       <= '0;
        fifo_count <= '0;
      end else begin
        if (do_push) wptr <= wptr + AW'(1);
        if (do_pop)  rptr <= rptr + AW'(1);
        if (do_push && !do_pop)      fifo_count <= fifo_count + (AW+1)'(1);
        else if (do_pop && !do_push) fifo_count <= fifo_count - (AW+1)'(1);
      end
      if (ovr_set)      overrun_o <= 1'b1;
      else if (ovr_clr) overrun_o <= 1'b0;
      if (to_evt || (state != S_IDLE))          to_cnt <= '0;
      else if (tick && (to_cnt < TW'(TO_LIMIT))) to_cnt <= to_cnt + TW'(1);
      if (to_evt)                                        timeout_flag <= 1'b0;
      else if (rd_valid && (to_cnt >= TW'(TO_LIMIT)))    timeout_flag <= 1'b1;
      irq_o <= ((trig_level != '0) && (fifo_count >= trig_level)) || timeout_flag;
    end
  end

endmodule
